// File: rtl/v_ch_pkg.sv
// rtl/v_ch_pkg.sv - transfer size codes and size-to-byte-count helper shared by v_ch_pack_fifo
package v_ch_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/v_byte_lane_fifo.sv
// rtl/v_byte_lane_fifo.sv - one 8-bit byte lane of the packing FIFO
// Storage is unreset; occupancy is tracked by the parent, so only pointers live here.
module v_byte_lane_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wp] <= din;
  end

  assign dout = mem[rp];

endmodule

// File: rtl/v_ch_pack_fifo.sv
// rtl/v_ch_pack_fifo.sv - byte-packing FIFO with sized, lane-offset writes and reads
// Optional sticky protocol error flag built only when V_CH_PACK_FIFO_ERR_EN is defined.
module v_ch_pack_fifo
  import v_ch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                                  clk,
  input  logic                                  areset,
  input  logic                                  flush_i,
  input  logic                                  wr_valid_i,
  output logic                                  wr_ready_o,
  input  logic [DATA_W-1:0]                     wr_data_i,
  input  logic [1:0]                            wr_size_i,
  input  logic [$clog2(DATA_W/8)-1:0]           wr_offset_i,
  input  logic                                  rd_valid_i,
  output logic                                  rd_ready_o,
  input  logic [1:0]                            rd_size_i,
  input  logic [$clog2(DATA_W/8)-1:0]           rd_offset_i,
  output logic [DATA_W-1:0]                     rd_data_o,
  output logic                                  rd_data_valid_o,
  output logic [$clog2(DATA_W/8*DEPTH):0]       level_o,
  output logic                                  empty_o,
  output logic                                  full_o,
  output logic                                  err_o,
  input  logic                                  err_clr_i
);

  localparam int BYTES = DATA_W / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int CAP   = BYTES * DEPTH;
  localparam int PW    = $clog2(CAP);
  localparam int LW    = PW + 1;
  localparam logic [3:0]    BYTES_N = 4'(BYTES);
  localparam logic [LW-1:0] CAP_N   = LW'(CAP);

  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [3:0]        wr_nb;
  logic [3:0]        rd_nb;
  logic [LW-1:0]     n_wr;
  logic [LW-1:0]     n_rd;
  logic              wr_legal;
  logic              rd_legal;
  logic              wr_acc;
  logic              rd_acc;
  logic [BYTES-1:0]  push;
  logic [BYTES-1:0]  pop;
  logic [7:0]        din  [BYTES];
  logic [7:0]        dout [BYTES];
  logic [DATA_W-1:0] rd_next;

  assign wr_nb    = size_bytes(wr_size_i);
  assign rd_nb    = size_bytes(rd_size_i);
  assign wr_legal = (wr_nb <= BYTES_N);
  assign rd_legal = (rd_nb <= BYTES_N);
  assign n_wr     = LW'(wr_nb);
  assign n_rd     = LW'(rd_nb);

  assign wr_ready_o = !flush_i && wr_legal && ((CAP_N - level_o) >= n_wr);
  assign rd_ready_o = !flush_i && rd_legal && (level_o >= n_rd);
  assign wr_acc     = wr_valid_i && wr_ready_o;
  assign rd_acc     = rd_valid_i && rd_ready_o;

  assign empty_o = (level_o == '0);
  assign full_o  = (level_o == CAP_N);

  // j is the transfer byte index that maps onto lane k; lanes with j >= n are untouched.
  always_comb begin
    logic [LB-1:0] j;
    logic [LB-1:0] l;
    push    = '0;
    pop     = '0;
    rd_next = '0;
    for (int k = 0; k < BYTES; k++) begin
      j       = LB'(k) - wptr[LB-1:0];
      l       = wr_offset_i + j;
      din[k]  = wr_data_i[8*l +: 8];
      push[k] = wr_acc && (LW'(j) < n_wr);
      j       = LB'(k) - rptr[LB-1:0];
      pop[k]  = rd_acc && (LW'(j) < n_rd);
      j       = LB'(k) - rd_offset_i;
      l       = rptr[LB-1:0] + j;
      if (LW'(j) < n_rd) rd_next[8*k +: 8] = dout[l];
    end
  end

  for (genvar g = 0; g < BYTES; g++) begin : g_lane
    v_byte_lane_fifo #(
      .DEPTH(DEPTH)
    ) u_lane (
      .clk   (clk),
      .areset(areset),
      .flush (flush_i),
      .push  (push[g]),
      .din   (din[g]),
      .pop   (pop[g]),
      .dout  (dout[g])
    );
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wptr            <= '0;
      rptr            <= '0;
      level_o         <= '0;
      rd_data_o       <= '0;
      rd_data_valid_o <= 1'b0;
    end else begin
      rd_data_valid_o <= rd_acc;
      if (rd_acc) rd_data_o <= rd_next;
      if (flush_i) begin
        wptr    <= '0;
        rptr    <= '0;
        level_o <= '0;
      end else begin
        if (wr_acc) wptr <= wptr + PW'(n_wr);
        if (rd_acc) rptr <= rptr + PW'(n_rd);
        level_o <= level_o + (wr_acc ? n_wr : '0) - (rd_acc ? n_rd : '0);
      end
    end
  end

`ifdef V_CH_PACK_FIFO_ERR_EN
  logic err_set;

  assign err_set = (wr_valid_i && (!wr_legal || (|(wr_offset_i & LB'(wr_nb - 4'd1))))) ||
                   (rd_valid_i && (!rd_legal || (|(rd_offset_i & LB'(rd_nb - 4'd1)))));

  always_ff @(posedge clk or negedge areset) begin
    if (!areset)        err_o <= 1'b0;
    else if (err_set)   err_o <= 1'b1;
    else if (err_clr_i) err_o <= 1'b0;
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_v_ch_pack_fifo.sv
// tb/tb_v_ch_pack_fifo.sv - self-checking bench for v_ch_pack_fifo (DATA_W=32, DEPTH=2)
// Reference model is a plain byte queue; error checks adapt to V_CH_PACK_FIFO_ERR_EN.
module tb_v_ch_pack_fifo;

  logic        clk = 1'b0;
  logic        areset;
  logic        flush_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [31:0] wr_data_i;
  logic [1:0]  wr_size_i;
  logic [1:0]  wr_offset_i;
  logic        rd_valid_i;
  logic        rd_ready_o;
  logic [1:0]  rd_size_i;
  logic [1:0]  rd_offset_i;
  logic [31:0] rd_data_o;
  logic        rd_data_valid_o;
  logic [3:0]  level_o;
  logic        empty_o;
  logic        full_o;
  logic        err_o;
  logic        err_clr_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] mq[$];

  always #5 clk = ~clk;

  v_ch_pack_fifo #(.DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .areset(areset), .flush_i(flush_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .wr_size_i(wr_size_i), .wr_offset_i(wr_offset_i),
    .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .rd_size_i(rd_size_i),
    .rd_offset_i(rd_offset_i), .rd_data_o(rd_data_o), .rd_data_valid_o(rd_data_valid_o),
    .level_o(level_o), .empty_o(empty_o), .full_o(full_o),
    .err_o(err_o), .err_clr_i(err_clr_i)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid_i = 1'b0;
    rd_valid_i = 1'b0;
    flush_i    = 1'b0;
    err_clr_i  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] sz, input logic [1:0] off, input logic [31:0] d);
    wr_valid_i = 1'b1; wr_size_i = sz; wr_offset_i = off; wr_data_i = d;
  endtask

  task automatic rd(input logic [1:0] sz, input logic [1:0] off);
    rd_valid_i = 1'b1; rd_size_i = sz; rd_offset_i = off;
  endtask

  task automatic test_reset();
    areset = 1'b0; idle();
    wr_size_i = 0; wr_offset_i = 0; wr_data_i = 0; rd_size_i = 0; rd_offset_i = 0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (level_o !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level_o); end
    n_tests++; if ({empty_o, full_o, rd_data_valid_o, err_o} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 1000", {empty_o, full_o, rd_data_valid_o, err_o}); end
    n_tests++; if (rd_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rd_data_o); end
    @(negedge clk); areset = 1'b1;
    step();
  endtask

  task automatic test_byte_word();
    logic [31:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      wr(0, 0, vals[i]);
      @(negedge clk);
      n_tests++; if (wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL bw_wr_ready%0d got %b exp 1", i, wr_ready_o); end
      step();
    end
    idle();
    n_tests++; if (level_o !== 4'd4) begin n_fail++; $display("FAIL bw_level4 got %0d exp 4", level_o); end
    rd(2, 0); step(); idle();
    n_tests++; if (rd_data_o !== 32'h44332211 || rd_data_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL bw_word_read got %h/%b exp 44332211/1", rd_data_o, rd_data_valid_o); end
    n_tests++; if (level_o !== 4'd0) begin n_fail++; $display("FAIL bw_level0 got %0d exp 0", level_o); end
    step();
    n_tests++; if (rd_data_o !== 32'h44332211 || rd_data_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL bw_hold got %h/%b exp 44332211/0", rd_data_o, rd_data_valid_o); end
  endtask

  task automatic test_half_offset();
    wr(1, 2, 32'hBBAA0000); step(); idle();
    rd(0, 1); step();
    n_tests++; if (rd_data_o !== 32'h0000AA00 || rd_data_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL half_rd0 got %h/%b exp 0000aa00/1", rd_data_o, rd_data_valid_o); end
    step(); idle();
    n_tests++; if (rd_data_o !== 32'h0000BB00) begin n_fail++; $display("FAIL half_rd1 got %h exp 0000bb00", rd_data_o); end
    n_tests++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL half_empty got %b exp 1", empty_o); end
  endtask

  task automatic test_full_simul();
    wr(2, 0, 32'h04030201); step();
    wr(2, 0, 32'h08070605); step();
    wr(0, 0, 32'h000000EE);
    @(negedge clk);
    n_tests++; if (full_o !== 1'b1 || wr_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL full_flags got full=%b wr_ready=%b exp 1/0", full_o, wr_ready_o); end
    step(); idle();
    n_tests++; if (level_o !== 4'd8) begin n_fail++; $display("FAIL full_level got %0d exp 8", level_o); end
    rd(2, 0); step();
    n_tests++; if (rd_data_o !== 32'h04030201 || level_o !== 4'd4) begin
      n_fail++; $display("FAIL full_rd0 got %h lvl %0d exp 04030201 lvl 4", rd_data_o, level_o); end
    wr(2, 0, 32'h0C0B0A09); step(); idle();
    n_tests++; if (rd_data_o !== 32'h08070605 || level_o !== 4'd4) begin
      n_fail++; $display("FAIL simul got %h lvl %0d exp 08070605 lvl 4", rd_data_o, level_o); end
    rd(2, 0); step(); idle();
    n_tests++; if (rd_data_o !== 32'h0C0B0A09 || level_o !== 4'd0) begin
      n_fail++; $display("FAIL simul_after got %h lvl %0d exp 0c0b0a09 lvl 0", rd_data_o, level_o); end
  endtask

  task automatic test_random_wrap();
    int xfers = 0;
    int bytes = 0;
    int cyc   = 0;
    mq.delete();
    while ((xfers < 30 || bytes <= 24) && cyc < 400) begin
      int nw, nr, wo, ro;
      bit ew, er, wa, ra;
      logic [31:0] ed;
      cyc++;
      wr_size_i   = 2'($urandom_range(0, 2));
      rd_size_i   = 2'($urandom_range(0, 2));
      nw = 1 << wr_size_i;
      nr = 1 << rd_size_i;
      wo = $urandom_range(0, 3) & ~(nw - 1);
      ro = $urandom_range(0, 3) & ~(nr - 1);
      wr_offset_i = 2'(wo);
      rd_offset_i = 2'(ro);
      wr_data_i   = $urandom;
      wr_valid_i  = ($urandom_range(0, 99) < 60);
      rd_valid_i  = ($urandom_range(0, 99) < 55);
      ew = (8 - mq.size() >= nw);
      er = (mq.size() >= nr);
      @(negedge clk);
      n_tests++; if (wr_ready_o !== ew || rd_ready_o !== er) begin
        n_fail++; $display("FAIL rnd_ready cyc %0d got %b%b exp %b%b", cyc, wr_ready_o, rd_ready_o, ew, er); end
      wa = wr_valid_i && ew;
      ra = rd_valid_i && er;
      ed = '0;
      if (ra) for (int j = 0; j < nr; j++) ed[8*((ro + j) % 4) +: 8] = mq.pop_front();
      if (wa) for (int j = 0; j < nw; j++) mq.push_back(wr_data_i[8*((wo + j) % 4) +: 8]);
      if (wa) begin xfers++; bytes += nw; end
      if (ra) begin xfers++; bytes += nr; end
      step();
      n_tests++; if (rd_data_valid_o !== ra) begin
        n_fail++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, rd_data_valid_o, ra); end
      if (ra) begin
        n_tests++; if (rd_data_o !== ed) begin
          n_fail++; $display("FAIL rnd_data cyc %0d got %h exp %h", cyc, rd_data_o, ed); end
      end
      n_tests++; if (level_o !== 4'(mq.size())) begin
        n_fail++; $display("FAIL rnd_level cyc %0d got %0d exp %0d", cyc, level_o, mq.size()); end
    end
    idle();
    n_tests++; if (cyc >= 400) begin n_fail++; $display("FAIL rnd_budget got %0d xfers exp 30", xfers); end
    while (mq.size() > 0) begin rd(0, 0); void'(mq.pop_front()); step(); end
    idle();
  endtask

  task automatic test_flush_reset();
    logic [31:0] pd;
    wr(2, 0, 32'hA1A2A3A4); step();
    wr(0, 0, 32'h000000A5); step();
    n_tests++; if (level_o !== 4'd5) begin n_fail++; $display("FAIL flush_pre_level got %0d exp 5", level_o); end
    pd = rd_data_o;
    flush_i = 1'b1;
    @(negedge clk);
    n_tests++; if (wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_wr_ready got %b exp 0", wr_ready_o); end
    step(); idle();
    n_tests++; if (level_o !== 4'd0 || empty_o !== 1'b1 || rd_data_o !== pd) begin
      n_fail++; $display("FAIL flush_state got lvl %0d empty %b data %h exp 0/1/%h", level_o, empty_o, rd_data_o, pd); end
    wr(0, 0, 32'h0000005A); step(); idle();
    rd(0, 0); step(); idle();
    n_tests++; if (rd_data_o !== 32'h0000005A) begin n_fail++; $display("FAIL flush_ptr_zero got %h exp 5a", rd_data_o); end
    wr(2, 0, 32'h11223344); step();
    wr(0, 0, 32'h00000077);
    #2 areset = 1'b0;
    #1;
    n_tests++; if (level_o !== 4'd0 || rd_data_o !== 32'h0 || {empty_o, full_o, rd_data_valid_o, err_o} !== 4'b1000) begin
      n_fail++; $display("FAIL areset_mid got lvl %0d data %h flags %b exp 0/0/1000", level_o, rd_data_o,
                         {empty_o, full_o, rd_data_valid_o, err_o}); end
    idle();
    @(negedge clk); areset = 1'b1;
    step();
    wr(1, 0, 32'h0000C3C2); step(); idle();
    rd(1, 2); step(); idle();
    n_tests++; if (rd_data_o !== 32'hC3C20000) begin n_fail++; $display("FAIL areset_after got %h exp c3c20000", rd_data_o); end
  endtask

`ifdef V_CH_PACK_FIFO_ERR_EN
  task automatic test_err();
    wr(2, 1, 32'hDDCCBBAA); step(); idle();
    n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_misalign got %b exp 1", err_o); end
    step();
    n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", err_o); end
    err_clr_i = 1'b1; step(); idle();
    n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", err_o); end
    wr(3, 0, 32'hFFFFFFFF);
    @(negedge clk);
    n_tests++; if (wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL err_sz3_ready got %b exp 0", wr_ready_o); end
    err_clr_i = 1'b1;
    step(); idle();
    n_tests++; if (err_o !== 1'b1 || level_o !== 4'd4) begin
      n_fail++; $display("FAIL err_sz3 got err %b lvl %0d exp 1/4", err_o, level_o); end
    err_clr_i = 1'b1; step(); idle();
    rd(2, 0); step(); idle();
    n_tests++; if (rd_data_o !== 32'hAADDCCBB || err_o !== 1'b0) begin
      n_fail++; $display("FAIL err_drain got %h err %b exp aaddccbb/0", rd_data_o, err_o); end
  endtask
`else
  task automatic test_err();
    wr(3, 1, 32'hFFFFFFFF);
    @(negedge clk);
    n_tests++; if (wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL noerr_ready got %b exp 0", wr_ready_o); end
    step(); idle();
    n_tests++; if (err_o !== 1'b0 || level_o !== 4'd0) begin
      n_fail++; $display("FAIL noerr_state got err %b lvl %0d exp 0/0", err_o, level_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_byte_word();
    test_half_offset();
    test_full_simul();
    test_random_wrap();
    test_flush_reset();
    test_err();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
